quad_frontend: RTL and testbench
================================

Name: quad_frontend

Overview:
- Conditions the raw quadrature encoder pins (A/B per motor) between the board pins and the hba_quad peripheral.
- Synchronizes each pin to the system clock, rejects glitches with a stability filter, and decodes Gray-code transitions into single-cycle step pulses with a direction flag and an error pulse.
- Provides a per-channel saturating error counter.
- Sits directly upstream of hba_quad, replacing the bare pin assigns on quad_enc_a/quad_enc_b.

Parameters:
- NUM_CH, 2, number of encoder channels (index 0 = left, 1 = right).
- FILTER_CYCLES, 4, consecutive clk cycles a synchronized input must differ from its filtered value before the filtered value updates; legal range 1..255.
- ERR_W, 8, width of each saturating error counter.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- enc_a  input  NUM_CH  raw encoder A pins, asynchronous to clk.
- enc_b  input  NUM_CH  raw encoder B pins, asynchronous to clk.
- err_clr  input  NUM_CH  per-channel synchronous clear of err_cnt; single-cycle pulse.
- a_filt  output  NUM_CH  filtered A level.
- b_filt  output  NUM_CH  filtered B level.
- step  output  NUM_CH  one-cycle pulse per valid quadrature transition.
- dir  output  NUM_CH  direction of the most recent step: 1 = forward, 0 = reverse; held between steps.
- err  output  NUM_CH  one-cycle pulse on an illegal transition (A and B change in the same cycle).
- err_cnt  output  NUM_CH*ERR_W  packed saturating error counts; channel i occupies bits [i*ERR_W +: ERR_W].
- ready  output  1  high once the INIT phase has completed.

Behaviour:
- Reset (async assert, released on clk):
  - All synchronizer flops, filter counters, a_filt, b_filt, step, dir, err and err_cnt go to 0.
  - ready goes to 0; the FSM enters INIT.
- Synchronizer: two flops per pin (a_s1→a_s2, b_s1→b_s2); no logic between the stages.
- Filter, per pin:
  - If the sync2 value equals the filtered value, the counter clears to 0.
  - Otherwise the counter increments. When the counter equals FILTER_CYCLES-1 while the value still differs, the filtered value takes the sync2 value on that edge and the counter clears.
  - Any return to equality before the update restarts the count.
- Latency from a pin change to a filtered change is 2 + FILTER_CYCLES clk edges. For FILTER_CYCLES=1, the filtered value follows sync2 with one edge of delay.
- FSM (one shared FSM for all channels):
  - INIT: the filters run normally. prev_state per channel loads {a_filt,b_filt} every cycle. step and err are forced to 0. A counter runs FILTER_CYCLES+3 cycles, then the FSM moves to RUN and ready goes to 1. This prevents a spurious step from pins that are nonzero at power-up.
  - RUN: each cycle, per channel, cur = {a_filt,b_filt} is compared with prev, then prev <= cur.
  - RUN persists until reset; there is no other exit.
- Decode, with state written as {a,b}:
  - Forward sequence: 00→01→11→10→00. A forward transition gives step=1 and dir=1 on the next edge.
  - Reverse sequence: 00→10→11→01→00. A reverse transition gives step=1 and dir=0.
  - cur == prev: no pulse; dir holds.
  - Both bits differ (00↔11, 01↔10): err=1, no step, dir holds. err_cnt increments and saturates at all-ones (never wraps).
- step and err are registered; each pulse asserts exactly one cycle after the a_filt/b_filt change.
- err_cnt:
  - err_clr in the same cycle as an err increment: the clear wins and the counter becomes 0.
  - err_clr is honored in both INIT and RUN.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Reset asserted mid-operation aborts everything immediately. Any partial filter count is discarded and INIT is re-run.

Test Plan:
- Reset, then enc_a=enc_b=1 held from before reset release → ready rises at cycle FILTER_CYCLES+3=7, a_filt=b_filt=1, and no step/err pulse ever appears.
- From 00 in RUN, drive ch0 through 01,11,10,00 with each level held 20 cycles → exactly 4 step pulses, dir=1. Each pulse appears 7 edges after its pin change (2 sync + 4 filter + 1 decode).
- Reverse sequence 00,10,11,01,00 on ch1 while ch0 is idle → 4 steps on ch1 with dir[1]=0; step[0] stays 0 throughout.
- 3-cycle glitch on enc_a[0] (FILTER_CYCLES=4) → a_filt unchanged, no step. A 4-cycle pulse → a_filt toggles twice and 2 steps are produced (forward then reverse).
- Change enc_a[0] and enc_b[0] on the same clk from 00 to 11 → one err pulse, err_cnt ch0 = 1, dir unchanged. Repeat 300 times → err_cnt saturates at 255. Pulse err_clr[0] in the same cycle as an err → err_cnt = 0.
- Assert reset in the middle of a filter count (pin differing for 2 cycles) → all outputs are 0 asynchronously, and after release ready returns after 7 cycles with no step.

Source files
------------

// File: rtl/quad_frontend.sv
// rtl/quad_frontend.sv - quadrature encoder pin conditioning: sync, glitch filter, step/dir/err decode
// Sits between the raw encoder pins and hba_quad.

module quad_pin_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_filt
);

  localparam logic [7:0] FLT_LAST = 8'(FILTER_CYCLES - 1);

  logic       r_s1;
  logic       r_s2;
  logic [7:0] r_cnt;
  logic       r_filt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_cnt  <= 8'd0;
      r_filt <= 1'b0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      // Any return to equality restarts the stability count.
      if (r_s2 == r_filt) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == FLT_LAST) begin
        r_filt <= r_s2;
        r_cnt  <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

module quad_frontend #(
  parameter int NUM_CH        = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic [NUM_CH-1:0]       err_clr,
  output logic [NUM_CH-1:0]       a_filt,
  output logic [NUM_CH-1:0]       b_filt,
  output logic [NUM_CH-1:0]       step,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH*ERR_W-1:0] err_cnt,
  output logic                    ready
);

  localparam logic [8:0] INIT_LAST = 9'(FILTER_CYCLES + 2);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [8:0] r_init_cnt;
  logic [8:0] w_init_cnt_nxt;
  logic       w_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 9'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // INIT lasts long enough for power-up pin levels to reach the filtered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 9'd1;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign w_run = (r_state == ST_RUN);
  assign ready = w_run;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             r_step;
    logic             r_dir;
    logic             r_err;
    logic [1:0]       r_prev;
    logic [ERR_W-1:0] r_err_cnt;
    logic [1:0]       w_cur;
    logic [1:0]       w_cur_pos;
    logic [1:0]       w_prev_pos;
    logic [1:0]       w_delta;
    logic             w_fwd;
    logic             w_rev;
    logic             w_bad;

    quad_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_flt_a (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (enc_a[g]),
      .o_filt (a_filt[g])
    );

    quad_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_flt_b (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (enc_b[g]),
      .o_filt (b_filt[g])
    );

    // Gray {a,b} to position 0..3: forward is +1, reverse is -1, +2 is a skipped state.
    assign w_cur      = {a_filt[g], b_filt[g]};
    assign w_cur_pos  = {w_cur[1], w_cur[1] ^ w_cur[0]};
    assign w_prev_pos = {r_prev[1], r_prev[1] ^ r_prev[0]};
    assign w_delta    = w_cur_pos - w_prev_pos;
    assign w_fwd      = w_run && (w_delta == 2'd1);
    assign w_rev      = w_run && (w_delta == 2'd3);
    assign w_bad      = w_run && (w_delta == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_prev    <= 2'b00;
        r_step    <= 1'b0;
        r_dir     <= 1'b0;
        r_err     <= 1'b0;
        r_err_cnt <= '0;
      end else begin
        r_prev <= w_cur;
        r_step <= w_fwd | w_rev;
        r_err  <= w_bad;
        if (w_fwd) begin
          r_dir <= 1'b1;
        end else if (w_rev) begin
          r_dir <= 1'b0;
        end
        if (err_clr[g]) begin
          r_err_cnt <= '0;
        end else if (w_bad && (r_err_cnt != {ERR_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end

    assign step[g]                 = r_step;
    assign dir[g]                  = r_dir;
    assign err[g]                  = r_err;
    assign err_cnt[g*ERR_W +: ERR_W] = r_err_cnt;
  end

endmodule

// File: tb/tb_quad_frontend.sv
// tb/tb_quad_frontend.sv - directed self-checking bench for quad_frontend
// Inputs change and outputs are sampled 1 time unit after the rising edge.

module tb_quad_frontend;

  localparam int NUM_CH = 2;
  localparam int ERR_W  = 8;

  logic                    clk     = 1'b0;
  logic                    reset   = 1'b1;
  logic [NUM_CH-1:0]       enc_a   = '0;
  logic [NUM_CH-1:0]       enc_b   = '0;
  logic [NUM_CH-1:0]       err_clr = '0;
  logic [NUM_CH-1:0]       a_filt;
  logic [NUM_CH-1:0]       b_filt;
  logic [NUM_CH-1:0]       step;
  logic [NUM_CH-1:0]       dir;
  logic [NUM_CH-1:0]       err;
  logic [NUM_CH*ERR_W-1:0] err_cnt;
  logic                    ready;

  int checks = 0;
  int errors = 0;
  int n_step0 = 0;
  int n_step1 = 0;
  int n_err0  = 0;
  int n_err1  = 0;
  int s_step0, s_step1, s_err0, s_err1;

  quad_frontend #(.NUM_CH(NUM_CH), .FILTER_CYCLES(4), .ERR_W(ERR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .err_clr (err_clr),
    .a_filt  (a_filt),
    .b_filt  (b_filt),
    .step    (step),
    .dir     (dir),
    .err     (err),
    .err_cnt (err_cnt),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (step[0]) n_step0 <= n_step0 + 1;
      if (step[1]) n_step1 <= n_step1 + 1;
      if (err[0])  n_err0  <= n_err0 + 1;
      if (err[1])  n_err1  <= n_err1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_step0 = n_step0;
    s_step1 = n_step1;
    s_err0  = n_err0;
    s_err1  = n_err1;
  endtask

  task automatic wait_ready();
    repeat (6) tick();
    check("ready_early", 32'(ready), 32'd0);
    tick();
    check("ready_rise", 32'(ready), 32'd1);
  endtask

  task automatic move(input int ch, input logic a, input logic b, input logic exp_dir);
    enc_a[ch] = a;
    enc_b[ch] = b;
    repeat (6) tick();
    check("step_early", 32'(step[ch]), 32'd0);
    tick();
    check("step_pulse", 32'(step[ch]), 32'd1);
    check("step_dir", 32'(dir[ch]), 32'(exp_dir));
    check("step_other", 32'(step[1-ch]), 32'd0);
    check("step_no_err", 32'(err[ch]), 32'd0);
    tick();
    check("step_single", 32'(step[ch]), 32'd0);
    repeat (12) tick();
  endtask

  initial begin
    // Power-up with all pins high: filters settle during INIT, no step or err.
    enc_a = 2'b11;
    enc_b = 2'b11;
    #12;
    check("rst_afilt", 32'(a_filt), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_errcnt", 32'(err_cnt), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    tick();
    reset = 1'b0;
    wait_ready();
    check("pwrup_afilt", 32'(a_filt), 32'd3);
    check("pwrup_bfilt", 32'(b_filt), 32'd3);
    repeat (20) tick();
    check("pwrup_nostep", 32'(n_step0 + n_step1), 32'd0);
    check("pwrup_noerr", 32'(n_err0 + n_err1), 32'd0);

    // Restart from all-zero pins.
    enc_a = 2'b00;
    enc_b = 2'b00;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wait_ready();

    // Forward sequence on ch0.
    snap();
    move(0, 1'b0, 1'b1, 1'b1);
    move(0, 1'b1, 1'b1, 1'b1);
    move(0, 1'b1, 1'b0, 1'b1);
    move(0, 1'b0, 1'b0, 1'b1);
    check("fwd_steps0", 32'(n_step0 - s_step0), 32'd4);
    check("fwd_steps1", 32'(n_step1 - s_step1), 32'd0);
    check("fwd_errs", 32'(n_err0 - s_err0), 32'd0);
    check("fwd_dir", 32'(dir[0]), 32'd1);

    // Reverse sequence on ch1, ch0 idle.
    snap();
    move(1, 1'b1, 1'b0, 1'b0);
    move(1, 1'b1, 1'b1, 1'b0);
    move(1, 1'b0, 1'b1, 1'b0);
    move(1, 1'b0, 1'b0, 1'b0);
    check("rev_steps1", 32'(n_step1 - s_step1), 32'd4);
    check("rev_steps0", 32'(n_step0 - s_step0), 32'd0);
    check("rev_dir1", 32'(dir[1]), 32'd0);
    check("rev_dir0", 32'(dir[0]), 32'd1);

    // Glitch rejection on enc_a[0] with ch0 sitting at 01.
    move(0, 1'b0, 1'b1, 1'b1);
    snap();
    enc_a[0] = 1'b1;
    repeat (3) tick();
    enc_a[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("glitch3_afilt", 32'(a_filt[0]), 32'd0);
    end
    check("glitch3_nostep", 32'(n_step0 - s_step0), 32'd0);

    // Four-cycle pulse passes: 01->11 forward, then 11->01 reverse.
    enc_a[0] = 1'b1;
    repeat (4) tick();
    enc_a[0] = 1'b0;
    check("pulse4_pre", 32'(a_filt[0]), 32'd0);
    repeat (2) tick();
    check("pulse4_rise", 32'(a_filt[0]), 32'd1);
    tick();
    check("pulse4_step1", 32'(step[0]), 32'd1);
    check("pulse4_dir1", 32'(dir[0]), 32'd1);
    repeat (3) tick();
    check("pulse4_fall", 32'(a_filt[0]), 32'd0);
    tick();
    check("pulse4_step2", 32'(step[0]), 32'd1);
    check("pulse4_dir2", 32'(dir[0]), 32'd0);
    repeat (10) tick();
    check("pulse4_steps", 32'(n_step0 - s_step0), 32'd2);

    // Back to 00 (01->00 is reverse), then illegal 00->11.
    move(0, 1'b0, 1'b0, 1'b0);
    snap();
    enc_a[0] = 1'b1;
    enc_b[0] = 1'b1;
    repeat (6) tick();
    check("err_early", 32'(err[0]), 32'd0);
    tick();
    check("err_pulse", 32'(err[0]), 32'd1);
    check("err_nostep", 32'(step[0]), 32'd0);
    check("err_cnt1", 32'(err_cnt[7:0]), 32'd1);
    check("err_dirhold", 32'(dir[0]), 32'd0);
    tick();
    check("err_single", 32'(err[0]), 32'd0);
    repeat (7) tick();

    // 299 more illegal transitions: counter saturates at 255.
    for (int i = 0; i < 299; i++) begin
      enc_a[0] = ~enc_a[0];
      enc_b[0] = ~enc_b[0];
      repeat (9) tick();
    end
    check("sat_cnt0", 32'(err_cnt[7:0]), 32'd255);
    check("sat_cnt1", 32'(err_cnt[15:8]), 32'd0);
    check("sat_pulses", 32'(n_err0 - s_err0), 32'd300);
    check("sat_nostep", 32'(n_step0 - s_step0), 32'd0);
    check("sat_dir", 32'(dir[0]), 32'd0);

    // Clear coincident with an err increment: clear wins.
    enc_a[0] = ~enc_a[0];
    enc_b[0] = ~enc_b[0];
    repeat (6) tick();
    err_clr[0] = 1'b1;
    tick();
    err_clr[0] = 1'b0;
    check("clr_err", 32'(err[0]), 32'd1);
    check("clr_cnt", 32'(err_cnt[7:0]), 32'd0);
    repeat (2) tick();
    enc_a[0] = ~enc_a[0];
    enc_b[0] = ~enc_b[0];
    repeat (7) tick();
    check("clr_recount", 32'(err_cnt[7:0]), 32'd1);
    repeat (2) tick();

    // Reset in the middle of a filter count.
    move(1, 1'b0, 1'b1, 1'b1);
    enc_a[0] = 1'b1;
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_afilt", 32'(a_filt), 32'd0);
    check("mid_bfilt", 32'(b_filt), 32'd0);
    check("mid_dir", 32'(dir), 32'd0);
    check("mid_errcnt", 32'(err_cnt), 32'd0);
    check("mid_ready", 32'(ready), 32'd0);
    tick();
    reset = 1'b0;
    snap();
    repeat (5) tick();
    check("mid_afilt_hold", 32'(a_filt[0]), 32'd0);
    tick();
    check("mid_afilt_rise", 32'(a_filt[0]), 32'd1);
    check("mid_bfilt_rise", 32'(b_filt[1]), 32'd1);
    check("mid_ready_early", 32'(ready), 32'd0);
    tick();
    check("mid_ready_rise", 32'(ready), 32'd1);
    repeat (20) tick();
    check("mid_nostep", 32'((n_step0 - s_step0) + (n_step1 - s_step1)), 32'd0);
    check("mid_noerr", 32'((n_err0 - s_err0) + (n_err1 - s_err1)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
